if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port imem_addr, output, 32 bits: instruction-memory word address (combinational from PC/FSM).
REQ-004 SHALL have port imem_data, input, 16 bits: word at imem_addr, valid in the same cycle.
REQ-005 SHALL have port stall, input, 1 bit: hold PC, FSM and IF/ID register.
REQ-006 SHALL have port flush, input, 1 bit: load NOP bubble into IF/ID.
REQ-007 SHALL have ports redirect_valid, input, 1 bit, and redirect_pc, input, 32 bits: jump/return target from downstream.
REQ-008 SHALL have port interrupt, input, 1 bit: external interrupt request, sampled each cycle.
REQ-009 SHALL have port instruction_r, output, 16 bits: IF/ID instruction to the decode stage.
REQ-010 SHALL have port pc_r, output, 32 bits: IF/ID address of instruction_r, or the return PC on interrupt.
REQ-011 SHALL have port imm_r, output, 16 bits: IF/ID second word of a two-word instruction, else 0.
REQ-012 SHALL have ports interrupt_signal_r, output, 1 bit, and valid_r, output, 1 bit: IF/ID interrupt marker and slot valid.

Function
REQ-013 SHALL use FSM states BOOT_LO, BOOT_HI, FETCH, IMM2.
REQ-014 BOOT_LO SHALL drive imem_addr=0 and capture the word as PC[15:0]; BOOT_HI SHALL drive imem_addr=1 and capture PC[31:16]; the FSM then enters FETCH; IF/ID holds NOP with valid_r=0 throughout.
REQ-015 In FETCH, when imem_data[15:14]==TWO_WORD_PREFIX, the block SHALL latch the word and its PC, set PC=PC+1, enter IMM2, and load a NOP bubble into IF/ID.
REQ-016 In IMM2, the block SHALL load instruction_r=latched word, imm_r=imem_data, pc_r=latched PC and valid_r=1, then set PC=PC+1 and return to FETCH.
REQ-017 For a one-word instruction in FETCH, the block SHALL load instruction_r=imem_data, pc_r=PC, imm_r=0 and valid_r=1 into IF/ID, and set PC=PC+1.
REQ-018 Each cycle a rising edge on interrupt SHALL set int_pending; further requests while it is pending SHALL merge.
REQ-019 When int_pending=1, the FSM is in FETCH and there is no stall or redirect, the block SHALL load instruction_r=NOP, pc_r=PC, interrupt_signal_r=1 and valid_r=1 into IF/ID for exactly one cycle, hold PC, and clear int_pending.
REQ-020 Priority SHALL be: reset > redirect_valid > stall > flush > normal.
REQ-021 redirect_valid SHALL load PC=redirect_pc, force the FSM to FETCH (aborting IMM2 and discarding the latched word), and load a NOP bubble, including when stall is asserted.
REQ-022 stall SHALL freeze PC, FSM, the latched word, and all IF/ID outputs; int_pending SHALL still capture new requests.
REQ-023 flush without redirect SHALL load a bubble while PC and the FSM advance normally.
REQ-024 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFF+1 SHALL wrap to 0.
REQ-025 A bubble SHALL mean instruction_r=NOP, imm_r=0, interrupt_signal_r=0 and valid_r=0, with pc_r unchanged.

Reset
REQ-026 Asserting reset SHALL immediately force: FSM=BOOT_LO (or FETCH, per REQ-028), PC=0 (or RESET_PC), int_pending=0, latched word=0, and all IF/ID outputs to the bubble with pc_r=0.
REQ-027 Reset asserted during IMM2 or an interrupt injection SHALL discard all in-flight state; no partial instruction SHALL appear after release.

Configuration
REQ-028 With IF_BOOT_VECTOR_EN defined, the block SHALL perform the BOOT_LO/BOOT_HI sequence; without it, the BOOT states SHALL be absent and reset SHALL load PC=RESET_PC and FSM=FETCH.

Structure
REQ-029 Package if_pkg SHALL hold: the FSM state enum, NOP (16'h0000), TWO_WORD_PREFIX (2'b11) and RESET_PC (32'h0000_0020).
REQ-030 IF/ID outputs SHALL be a sub-module if_id_reg (66 bits wide) with enable (~stall) and bubble inputs; the FSM, PC and int_pending SHALL stay in if_stage.

Verification
REQ-031 Boot test: with M[0]=16'h0040 and M[1]=16'h0000, release reset -> after 2 cycles PC=32'h40, and the next cycle instruction_r=M[0x40] with valid_r=1.
REQ-032 Two-word test: M[0x40]=16'hC100 and M[0x41]=16'h1234 -> one bubble, then instruction_r=16'hC100, imm_r=16'h1234 and pc_r=32'h40; the next fetch is from 0x42.
REQ-033 Stall+redirect test: stall held 3 cycles -> outputs frozen; redirect_valid with 32'h100 during stall -> bubble, and the next fetch is from 0x100.
REQ-034 Interrupt test: interrupt pulsed at PC=0x45 -> one slot with interrupt_signal_r=1 and pc_r=32'h45, PC held; a second pulse while pending -> only one injection.
REQ-035 Abort test: redirect_valid in IMM2 -> the latched word is never emitted; reset mid-IMM2 -> bubble outputs and boot restarts.
REQ-036 Wrap test: PC=32'hFFFF_FFFF with a one-word instruction -> the next PC is 32'h0.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// IF_BOOT_VECTOR_EN selects the two-word boot-vector load after reset.
package if_pkg;

  typedef enum logic [1:0] {
    BOOT_LO = 2'd0,
    BOOT_HI = 2'd1,
    FETCH   = 2'd2,
    IMM2    = 2'd3
  } if_state_e;

  localparam logic [15:0] NOP             = 16'h0000;
  localparam logic [1:0]  TWO_WORD_PREFIX = 2'b11;
  localparam logic [31:0] RESET_PC        = 32'h0000_0020;
  localparam int          IF_ID_W         = 66;

  // One IF/ID slot; packs to exactly IF_ID_W bits.
  typedef struct packed {
    logic [15:0] instruction;
    logic [31:0] pc;
    logic [15:0] imm;
    logic        interrupt_signal;
    logic        valid;
  } if_id_t;

  function automatic logic is_two_word(input logic [15:0] word);
    return word[15:14] == TWO_WORD_PREFIX;
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: holds when en is low, loads a bubble
// (NOP, no immediate, not valid, pc kept) when bubble is high.
module if_id_reg
  import if_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  // Slot update: hold, bubble, or load the new fetch result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.instruction      <= NOP;
      q.pc               <= '0;
      q.imm              <= '0;
      q.interrupt_signal <= 1'b0;
      q.valid            <= 1'b0;
    end else if (en) begin
      if (bubble) begin
        q.instruction      <= NOP;
        q.imm              <= '0;
        q.interrupt_signal <= 1'b0;
        q.valid            <= 1'b0;
      end else begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, fetch FSM, interrupt injection, IF/ID slot.
// Optional feature: IF_BOOT_VECTOR_EN loads the start PC from words 0/1.
// Flow: valid_r marks a real instruction in IF/ID; stall is backpressure
// from decode and freezes everything except interrupt capture; redirect
// overrides stall and always leaves a bubble behind it.
module if_stage
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        interrupt,
  output logic [15:0] instruction_r,
  output logic [31:0] pc_r,
  output logic [15:0] imm_r,
  output logic        interrupt_signal_r,
  output logic        valid_r,
  output if_state_e   state_dbg
);

`ifdef IF_BOOT_VECTOR_EN
  localparam if_state_e   RST_STATE = BOOT_LO;
  localparam logic [31:0] RST_PC    = 32'h0;
`else
  localparam if_state_e   RST_STATE = FETCH;
  localparam logic [31:0] RST_PC    = RESET_PC;
`endif

  if_state_e   state;
  logic [31:0] pc;
  logic        int_pending;
  logic        int_prev;
  logic [15:0] lat_word;
  logic [31:0] lat_pc;

  if_id_t id_d;
  if_id_t id_q;
  logic   id_bubble;
  logic   take_int;
  logic   advance;
  logic   int_rise;

  assign advance   = !redirect_valid && !stall;
  assign int_rise  = interrupt && !int_prev;
  assign state_dbg = state;

  // Memory address: boot vector words during boot, otherwise the PC.
  always_comb begin
    imem_addr = pc;
    case (state)
`ifdef IF_BOOT_VECTOR_EN
      BOOT_LO: imem_addr = 32'd0;
      BOOT_HI: imem_addr = 32'd1;
`endif
      default: imem_addr = pc;
    endcase
  end

  // Next IF/ID contents; anything that is not a completed fetch is a bubble.
  always_comb begin
    id_d      = '0;
    id_d.pc   = pc;
    id_bubble = 1'b1;
    take_int  = 1'b0;
    case (state)
      FETCH: begin
        if (int_pending) begin
          take_int              = 1'b1;
          id_d.instruction      = NOP;
          id_d.interrupt_signal = 1'b1;
          id_d.valid            = 1'b1;
          id_bubble             = 1'b0;
        end else if (!is_two_word(imem_data)) begin
          id_d.instruction = imem_data;
          id_d.valid       = 1'b1;
          id_bubble        = 1'b0;
        end
      end
      IMM2: begin
        id_d.instruction = lat_word;
        id_d.imm         = imem_data;
        id_d.pc          = lat_pc;
        id_d.valid       = 1'b1;
        id_bubble        = 1'b0;
      end
      default: ;
    endcase
    // A flush landing on an injection slot drops that interrupt.
    if (redirect_valid || flush) id_bubble = 1'b1;
  end

  // FSM, PC, latched first word and interrupt request tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RST_STATE;
      pc          <= RST_PC;
      int_pending <= 1'b0;
      int_prev    <= 1'b0;
      lat_word    <= NOP;
      lat_pc      <= '0;
    end else begin
      int_prev    <= interrupt;
      int_pending <= (int_pending && !(take_int && advance)) || int_rise;
      if (redirect_valid) begin
        pc       <= redirect_pc;
        state    <= FETCH;
        lat_word <= NOP;
        lat_pc   <= '0;
      end else if (!stall) begin
        case (state)
`ifdef IF_BOOT_VECTOR_EN
          BOOT_LO: begin
            pc[15:0] <= imem_data;
            state    <= BOOT_HI;
          end
          BOOT_HI: begin
            pc[31:16] <= imem_data;
            state     <= FETCH;
          end
`endif
          FETCH: begin
            // An injection holds the PC so the return address is exact.
            if (!int_pending) begin
              if (is_two_word(imem_data)) begin
                lat_word <= imem_data;
                lat_pc   <= pc;
                state    <= IMM2;
              end
              pc <= pc + 32'd1;
            end
          end
          IMM2: begin
            pc    <= pc + 32'd1;
            state <= FETCH;
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

  if_id_reg u_if_id_reg (
    .clk    (clk),
    .reset  (reset),
    .en     (!stall || redirect_valid),
    .bubble (id_bubble),
    .d      (id_d),
    .q      (id_q)
  );

  assign instruction_r      = id_q.instruction;
  assign pc_r               = id_q.pc;
  assign imm_r              = id_q.imm;
  assign interrupt_signal_r = id_q.interrupt_signal;
  assign valid_r            = id_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a small behavioural instruction memory.
module tb_if_stage;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        interrupt = 1'b0;
  logic [15:0] instruction_r;
  logic [31:0] pc_r;
  logic [15:0] imm_r;
  logic        interrupt_signal_r;
  logic        valid_r;
  if_state_e   state_dbg;

  logic [15:0] mem [0:1023];
  int total = 0;
  int bad   = 0;

  // clock
  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[9:0]];

  if_stage dut (
    .clk                (clk),
    .reset              (reset),
    .imem_addr          (imem_addr),
    .imem_data          (imem_data),
    .stall              (stall),
    .flush              (flush),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .interrupt          (interrupt),
    .instruction_r      (instruction_r),
    .pc_r               (pc_r),
    .imm_r              (imm_r),
    .interrupt_signal_r (interrupt_signal_r),
    .valid_r            (valid_r),
    .state_dbg          (state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_slot(input string tag, input logic [15:0] ins, input logic [31:0] pc,
                          input logic [15:0] imm, input logic intr, input logic vld);
    chk({tag, ".ins"},   32'(instruction_r),      32'(ins));
    chk({tag, ".pc"},    pc_r,                    pc);
    chk({tag, ".imm"},   32'(imm_r),              32'(imm));
    chk({tag, ".int"},   32'(interrupt_signal_r), 32'(intr));
    chk({tag, ".valid"}, 32'(valid_r),            32'(vld));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h1000 + 16'(i);
    mem[16'h40] = 16'hC100;
    mem[16'h41] = 16'h1234;
`ifdef IF_BOOT_VECTOR_EN
    mem[0] = 16'h0040;
    mem[1] = 16'h0000;
`endif

    // reset state
    step();
    step();
    chk_slot("reset", NOP, 32'h0, 16'h0, 1'b0, 1'b0);
`ifdef IF_BOOT_VECTOR_EN
    chk("reset.addr", imem_addr, 32'h0);
    reset = 1'b1;
    chk("boot.lo_addr", imem_addr, 32'h0);
    step();
    chk("boot.hi_addr", imem_addr, 32'h1);
    chk("boot.hi_valid", 32'(valid_r), 32'h0);
    step();
    chk("boot.pc", imem_addr, 32'h40);
    chk("boot.valid", 32'(valid_r), 32'h0);
`else
    chk("reset.addr", imem_addr, 32'h20);
    reset = 1'b1;
    step();
    chk_slot("first", 16'h1020, 32'h20, 16'h0, 1'b0, 1'b1);
    redirect_to(32'h40);
    chk_slot("redir40", NOP, 32'h20, 16'h0, 1'b0, 1'b0);
    chk("redir40.addr", imem_addr, 32'h40);
`endif

    // two-word instruction
    step();
    chk("tw.bubble", 32'(valid_r), 32'h0);
    chk("tw.state", 32'(state_dbg), 32'(IMM2));
    chk("tw.addr", imem_addr, 32'h41);
    step();
    chk_slot("tw", 16'hC100, 32'h40, 16'h1234, 1'b0, 1'b1);
    chk("tw.next_addr", imem_addr, 32'h42);
    step();
    chk_slot("after_tw", 16'h1042, 32'h42, 16'h0, 1'b0, 1'b1);

    // stall then redirect under stall
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_slot("stall", 16'h1042, 32'h42, 16'h0, 1'b0, 1'b1);
      chk("stall.addr", imem_addr, 32'h43);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    chk_slot("stall_redir", NOP, 32'h42, 16'h0, 1'b0, 1'b0);
    chk("stall_redir.addr", imem_addr, 32'h100);
    stall          = 1'b0;
    redirect_valid = 1'b0;
    step();
    chk_slot("fetch100", 16'h1100, 32'h100, 16'h0, 1'b0, 1'b1);

    // interrupt injection at PC 0x45
    redirect_to(32'h44);
    interrupt = 1'b1;
    step();
    chk_slot("pre_int", 16'h1044, 32'h44, 16'h0, 1'b0, 1'b1);
    interrupt = 1'b0;
    step();
    chk_slot("int", NOP, 32'h45, 16'h0, 1'b1, 1'b1);
    chk("int.addr", imem_addr, 32'h45);
    step();
    chk_slot("post_int", 16'h1045, 32'h45, 16'h0, 1'b0, 1'b1);

    // two requests merge while pending (held pending by a stall)
    interrupt = 1'b1;
    step();
    chk_slot("merge.e1", 16'h1046, 32'h46, 16'h0, 1'b0, 1'b1);
    interrupt = 1'b0;
    stall     = 1'b1;
    step();
    interrupt = 1'b1;
    step();
    chk_slot("merge.stall", 16'h1046, 32'h46, 16'h0, 1'b0, 1'b1);
    interrupt = 1'b0;
    stall     = 1'b0;
    step();
    chk_slot("int2", NOP, 32'h47, 16'h0, 1'b1, 1'b1);
    step();
    chk_slot("no_dup", 16'h1047, 32'h47, 16'h0, 1'b0, 1'b1);

    // flush: bubble while the PC still advances
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_slot("flush", NOP, 32'h47, 16'h0, 1'b0, 1'b0);
    chk("flush.addr", imem_addr, 32'h49);

    // redirect aborts IMM2
    redirect_to(32'h40);
    step();
    chk("abort.state", 32'(state_dbg), 32'(IMM2));
    redirect_to(32'h50);
    chk("abort.bubble", 32'(valid_r), 32'h0);
    chk("abort.fsm", 32'(state_dbg), 32'(FETCH));
    step();
    chk_slot("abort", 16'h1050, 32'h50, 16'h0, 1'b0, 1'b1);

    // reset in the middle of IMM2
    redirect_to(32'h40);
    step();
    chk("rst_imm2.pre", 32'(state_dbg), 32'(IMM2));
    reset = 1'b0;
    #1;
    chk_slot("rst_imm2", NOP, 32'h0, 16'h0, 1'b0, 1'b0);
`ifdef IF_BOOT_VECTOR_EN
    chk("rst_imm2.state", 32'(state_dbg), 32'(BOOT_LO));
    step();
    reset = 1'b1;
    step();
    step();
    chk("rst_rel.addr", imem_addr, 32'h40);
    chk("rst_rel.valid", 32'(valid_r), 32'h0);
`else
    chk("rst_imm2.state", 32'(state_dbg), 32'(FETCH));
    step();
    reset = 1'b1;
    step();
    chk_slot("rst_rel", 16'h1020, 32'h20, 16'h0, 1'b0, 1'b1);
`endif

    // PC wrap
    redirect_to(32'hFFFF_FFFF);
    step();
    chk_slot("wrap", 16'h13FF, 32'hFFFF_FFFF, 16'h0, 1'b0, 1'b1);
    chk("wrap.addr", imem_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
